// File: rtl/axi4_slave_mem_responder.sv
// AXI4 slave memory model: word-addressed RAM that serves one write or read burst at a time.
// Returns per-beat responses and echoes IDs; out-of-range words and WRAP/reserved bursts answer SLVERR.
module axi4_slave_mem_responder #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int USER_WIDTH = 4,
   parameter int MEM_DEPTH  = 256
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic                    AWVALID,
   input  logic [ADDR_WIDTH-1:0]   AWADDR,
   input  logic [7:0]              AWLEN,
   input  logic [2:0]              AWSIZE,
   input  logic [1:0]              AWBURST,
   input  logic [ID_WIDTH-1:0]     AWID,
   input  logic [USER_WIDTH-1:0]   AWUSER,
   output logic                    AWREADY,
   input  logic                    WVALID,
   input  logic [DATA_WIDTH-1:0]   WDATA,
   input  logic [DATA_WIDTH/8-1:0] WSTRB,
   input  logic                    WLAST,
   input  logic [USER_WIDTH-1:0]   WUSER,
   output logic                    WREADY,
   output logic                    BVALID,
   output logic [1:0]              BRESP,
   output logic [ID_WIDTH-1:0]     BID,
   output logic [USER_WIDTH-1:0]   BUSER,
   input  logic                    BREADY,
   input  logic                    ARVALID,
   input  logic [ADDR_WIDTH-1:0]   ARADDR,
   input  logic [7:0]              ARLEN,
   input  logic [2:0]              ARSIZE,
   input  logic [1:0]              ARBURST,
   input  logic [ID_WIDTH-1:0]     ARID,
   input  logic [USER_WIDTH-1:0]   ARUSER,
   output logic                    ARREADY,
   output logic                    RVALID,
   output logic [DATA_WIDTH-1:0]   RDATA,
   output logic [1:0]              RRESP,
   output logic                    RLAST,
   output logic [ID_WIDTH-1:0]     RID,
   output logic [USER_WIDTH-1:0]   RUSER,
   input  logic                    RREADY
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int OFF    = $clog2(STRB_W);
   localparam int IDXW   = $clog2(MEM_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WRESP, S_RDATA} state_t;

   state_t                  state_q;
   logic                    pref_wr_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [7:0]              len_q;
   logic [7:0]              beat_q;
   logic [2:0]              size_q;
   logic [1:0]              burst_q;
   logic [ID_WIDTH-1:0]     id_q;
   logic                    err_q;
   logic                    bvalid_q;
   logic [1:0]              bresp_q;
   logic                    rvalid_q;
   logic                    rlast_q;
   logic [1:0]              rresp_q;
   logic [DATA_WIDTH-1:0]   rdata_q;

   logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

   logic                    aw_grant, ar_grant, w_hs, w_last_beat, w_ok, w_en, err_d;
   logic [ADDR_WIDTH-1:0]   step, addr_d, rd_addr;
   logic [1:0]              rd_burst, rd_resp;
   logic                    rd_ok;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic                    unused_sidebands;

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] w;
      w = a >> OFF;
      return (w >> IDXW) == '0;
   endfunction

   function automatic logic [IDXW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] w;
      w = a >> OFF;
      return w[IDXW-1:0];
   endfunction

   function automatic logic burst_ok(input logic [1:0] b);
      return (b == 2'b00) || (b == 2'b01);
   endfunction

   always_comb begin
      aw_grant    = (state_q == S_IDLE) && !ARESET && AWVALID && (!ARVALID || pref_wr_q);
      ar_grant    = (state_q == S_IDLE) && !ARESET && ARVALID && (!AWVALID || !pref_wr_q);
      w_hs        = (state_q == S_WDATA) && WVALID;
      w_last_beat = (beat_q == len_q);
      w_ok        = burst_ok(burst_q) && in_range(addr_q);
      w_en        = w_hs && w_ok;
      err_d       = err_q || (w_hs && (!w_ok || (WLAST != w_last_beat)));
      step        = ADDR_WIDTH'(1) << size_q;
      addr_d      = (burst_q == 2'b01) ? addr_q + step : addr_q;
      // Beat 0 is looked up from the AR channel itself; later beats from the advanced address.
      rd_addr     = ar_grant ? ARADDR : addr_d;
      rd_burst    = ar_grant ? ARBURST : burst_q;
      rd_ok       = burst_ok(rd_burst) && in_range(rd_addr);
      rd_word     = rd_ok ? mem[word_idx(rd_addr)] : '0;
      rd_resp     = rd_ok ? 2'b00 : 2'b10;
   end

   assign AWREADY = aw_grant;
   assign ARREADY = ar_grant;
   assign WREADY  = (state_q == S_WDATA);
   assign BVALID  = bvalid_q;
   assign BRESP   = bresp_q;
   assign BID     = id_q;
   assign BUSER   = '0;
   assign RVALID  = rvalid_q;
   assign RDATA   = rdata_q;
   assign RRESP   = rresp_q;
   assign RLAST   = rlast_q;
   assign RID     = id_q;
   assign RUSER   = '0;
   assign unused_sidebands = ^{AWUSER, WUSER, ARUSER};

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q   <= S_IDLE;
         pref_wr_q <= 1'b1;
         addr_q    <= '0;
         len_q     <= '0;
         beat_q    <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         id_q      <= '0;
         err_q     <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= '0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rresp_q   <= '0;
         rdata_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (aw_grant) begin
                  addr_q    <= AWADDR;
                  len_q     <= AWLEN;
                  size_q    <= AWSIZE;
                  burst_q   <= AWBURST;
                  id_q      <= AWID;
                  beat_q    <= '0;
                  err_q     <= 1'b0;
                  pref_wr_q <= ~pref_wr_q;
                  state_q   <= S_WDATA;
               end else if (ar_grant) begin
                  addr_q    <= ARADDR;
                  len_q     <= ARLEN;
                  size_q    <= ARSIZE;
                  burst_q   <= ARBURST;
                  id_q      <= ARID;
                  beat_q    <= '0;
                  pref_wr_q <= ~pref_wr_q;
                  rvalid_q  <= 1'b1;
                  rdata_q   <= rd_word;
                  rresp_q   <= rd_resp;
                  rlast_q   <= (ARLEN == 8'd0);
                  state_q   <= S_RDATA;
               end
            end
            S_WDATA: begin
               if (w_hs) begin
                  err_q  <= err_d;
                  beat_q <= beat_q + 8'd1;
                  addr_q <= addr_d;
                  if (w_last_beat) begin
                     bvalid_q <= 1'b1;
                     bresp_q  <= err_d ? 2'b10 : 2'b00;
                     state_q  <= S_WRESP;
                  end
               end
            end
            S_WRESP: begin
               if (BREADY) begin
                  bvalid_q <= 1'b0;
                  state_q  <= S_IDLE;
               end
            end
            S_RDATA: begin
               if (RREADY) begin
                  if (rlast_q) begin
                     rvalid_q <= 1'b0;
                     rlast_q  <= 1'b0;
                     state_q  <= S_IDLE;
                  end else begin
                     beat_q  <= beat_q + 8'd1;
                     addr_q  <= addr_d;
                     rdata_q <= rd_word;
                     rresp_q <= rd_resp;
                     rlast_q <= ((beat_q + 8'd1) == len_q);
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Memory has no reset so its contents survive ARESET.
   always_ff @(posedge ACLK) begin
      if (w_en) begin
         for (int unsigned b = 0; b < STRB_W; b++) begin
            if (WSTRB[b]) mem[word_idx(addr_q)][b*8 +: 8] <= WDATA[b*8 +: 8];
         end
      end
   end

endmodule
